// File: rtl/ysyx_bus_pkg.sv
// ysyx_bus_pkg: shared bus FSM states and AXI4 constants for ysyx bus arbiters
package ysyx_bus_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B,
    S_DONE
  } bus_state_e;
  localparam int AXI_DATA_W = 64;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] AXI_SIZE_B = 3'd0;
  localparam logic [2:0] AXI_SIZE_H = 3'd1;
  localparam logic [2:0] AXI_SIZE_W = 3'd2;
endpackage

// File: rtl/ysyx_rr_pick.sv
// ysyx_rr_pick: round-robin picker, first set request at or after ptr with wrap
module ysyx_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any_req
);
  int j;
  always_comb begin
    any_req = |req;
    idx = '0;
    j = 0;
    // Scan farthest offset first so the lowest offset from ptr wins
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NREQ;
      if (req[j]) idx = IDX_W'(j);
    end
  end
endmodule

// File: rtl/ysyx_bus_rr_arbiter.sv
// ysyx_bus_rr_arbiter: fair round-robin arbiter of NREQ single-beat requestors
// onto one AXI4 master port, one transaction in flight at a time.
module ysyx_bus_rr_arbiter
  import ysyx_bus_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*3-1:0]      req_size,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  input  logic [NREQ*4-1:0]      req_wstrb,
  output logic [NREQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic                   resp_err,
  output logic                   busy,
  output logic [ADDR_W-1:0]      io_master_araddr,
  output logic                   io_master_arvalid,
  output logic [3:0]             io_master_arid,
  output logic [7:0]             io_master_arlen,
  output logic [2:0]             io_master_arsize,
  output logic [1:0]             io_master_arburst,
  input  logic                   io_master_arready,
  input  logic [3:0]             io_master_rid,
  input  logic [AXI_DATA_W-1:0]  io_master_rdata,
  input  logic [1:0]             io_master_rresp,
  input  logic                   io_master_rlast,
  input  logic                   io_master_rvalid,
  output logic                   io_master_rready,
  output logic [ADDR_W-1:0]      io_master_awaddr,
  output logic                   io_master_awvalid,
  output logic [3:0]             io_master_awid,
  output logic [7:0]             io_master_awlen,
  output logic [2:0]             io_master_awsize,
  output logic [1:0]             io_master_awburst,
  input  logic                   io_master_awready,
  output logic [AXI_DATA_W-1:0]  io_master_wdata,
  output logic [7:0]             io_master_wstrb,
  output logic                   io_master_wlast,
  output logic                   io_master_wvalid,
  input  logic                   io_master_wready,
  input  logic [3:0]             io_master_bid,
  input  logic [1:0]             io_master_bresp,
  input  logic                   io_master_bvalid,
  output logic                   io_master_bready
);
  bus_state_e state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick_idx;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0] size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wstrb_q, wstrb_d, s_lane;
  logic write_q, write_d, err_q, err_d, aw_done_q, aw_done_d, w_done_q, w_done_d, any_req;
  logic [31:0] w_lane, r_lane;

  ysyx_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr_q),
    .idx(pick_idx),
    .any_req(any_req)
  );

  assign w_lane = 32'(wdata_q[31:0] << {addr_q[1:0], 3'b000});
  assign s_lane = wstrb_q << addr_q[1:0];
  assign r_lane = addr_q[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];

  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d = grant_q;
    addr_d = addr_q;
    size_d = size_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d = err_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    unique case (state_q)
      S_IDLE: if (any_req) begin
        grant_d = pick_idx;
        addr_d = req_addr[pick_idx*ADDR_W +: ADDR_W];
        size_d = req_size[pick_idx*3 +: 3];
        wdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
        wstrb_d = req_wstrb[pick_idx*4 +: 4];
        write_d = req_write[pick_idx];
        state_d = req_write[pick_idx] ? S_AW_W : S_AR;
      end
      S_AR: if (io_master_arready) state_d = S_R;
      S_R: if (io_master_rvalid) begin
        rdata_d = DATA_W'(r_lane);
        err_d = io_master_rresp != AXI_RESP_OKAY;
        state_d = S_DONE;
      end
      S_AW_W: begin
        aw_done_d = aw_done_q | io_master_awready;
        w_done_d = w_done_q | io_master_wready;
        // Clear both flags on exit so the next write starts with both valids up
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d = 1'b0;
          state_d = S_B;
        end
      end
      S_B: if (io_master_bvalid) begin
        err_d = io_master_bresp != AXI_RESP_OKAY;
        state_d = S_DONE;
      end
      S_DONE: begin
        rr_ptr_d = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q <= '0;
      addr_q <= '0;
      size_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q <= grant_d;
      addr_q <= addr_d;
      size_q <= size_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
    end
  end

  assign busy = state_q != S_IDLE;
  assign resp_valid = (state_q == S_DONE) ? NREQ'(1) << grant_q : '0;
  assign resp_rdata = rdata_q;
  assign resp_err = (state_q == S_DONE) & err_q;

  assign io_master_araddr = addr_q;
  assign io_master_arvalid = state_q == S_AR;
  assign io_master_arid = 4'(grant_q);
  assign io_master_arlen = 8'd0;
  assign io_master_arsize = size_q;
  assign io_master_arburst = AXI_BURST_INCR;
  assign io_master_rready = state_q == S_R;

  assign io_master_awaddr = addr_q;
  assign io_master_awvalid = (state_q == S_AW_W) & ~aw_done_q;
  assign io_master_awid = 4'(grant_q);
  assign io_master_awlen = 8'd0;
  assign io_master_awsize = size_q;
  assign io_master_awburst = AXI_BURST_INCR;
  assign io_master_wdata = {w_lane, w_lane};
  assign io_master_wstrb = addr_q[2] ? {s_lane, 4'b0} : {4'b0, s_lane};
  assign io_master_wlast = io_master_wvalid;
  assign io_master_wvalid = (state_q == S_AW_W) & ~w_done_q & write_q;
  assign io_master_bready = state_q == S_B;

  ap_rlast: assert property (@(posedge clk) disable iff (rst)
    io_master_rvalid |-> io_master_rlast);
  ap_rid: assert property (@(posedge clk) disable iff (rst)
    io_master_rvalid |-> io_master_rid == io_master_arid);
  ap_bid: assert property (@(posedge clk) disable iff (rst)
    io_master_bvalid |-> io_master_bid == io_master_awid);
  ap_r_state: assert property (@(posedge clk) disable iff (rst)
    io_master_rvalid |-> state_q == S_R);
  ap_b_state: assert property (@(posedge clk) disable iff (rst)
    io_master_bvalid |-> state_q == S_B);
endmodule

// File: tb/tb_ysyx_bus_rr_arbiter.sv
// tb_ysyx_bus_rr_arbiter: directed self-checking bench for the round-robin bus arbiter
module tb_ysyx_bus_rr_arbiter;
  localparam int NREQ = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_write = '0, resp_valid;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*3-1:0] req_size = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ*4-1:0] req_wstrb = '0;
  logic [DW-1:0] resp_rdata;
  logic resp_err, busy;
  logic [AW-1:0] araddr, awaddr;
  logic arvalid, arready = 1'b1, rready, rlast = 1'b1, rvalid = 1'b0;
  logic awvalid, awready = 1'b1, wlast, wvalid, wready = 1'b1, bvalid = 1'b0, bready;
  logic [3:0] arid, awid, rid = '0, bid = '0;
  logic [7:0] arlen, awlen, wstrb;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp = '0, bresp = '0;
  logic [63:0] rdata = '0, wdata;
  int n_chk = 0, n_fail = 0;
  int g;

  always #5 clk = ~clk;

  ysyx_bus_rr_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .io_master_araddr(araddr), .io_master_arvalid(arvalid), .io_master_arid(arid),
    .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
    .io_master_arready(arready),
    .io_master_rid(rid), .io_master_rdata(rdata), .io_master_rresp(rresp),
    .io_master_rlast(rlast), .io_master_rvalid(rvalid), .io_master_rready(rready),
    .io_master_awaddr(awaddr), .io_master_awvalid(awvalid), .io_master_awid(awid),
    .io_master_awlen(awlen), .io_master_awsize(awsize), .io_master_awburst(awburst),
    .io_master_awready(awready),
    .io_master_wdata(wdata), .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_wvalid(wvalid), .io_master_wready(wready),
    .io_master_bid(bid), .io_master_bresp(bresp), .io_master_bvalid(bvalid),
    .io_master_bready(bready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wd, input logic [3:0] st);
    req_valid[p] = 1'b1;
    req_write[p] = wr;
    req_addr[p*AW +: AW] = addr;
    req_size[p*3 +: 3] = size;
    req_wdata[p*DW +: DW] = wd;
    req_wstrb[p*4 +: 4] = st;
  endtask

  task automatic serve_read(input logic [63:0] data, input logic [1:0] resp, input int waits,
                            output int gid);
    for (int k = 0; k < 20 && !arvalid; k++) step();
    check("ar_seen", arvalid, 1);
    gid = int'(arid);
    step();
    repeat (waits) step();
    rvalid = 1'b1;
    rdata = data;
    rresp = resp;
    rlast = 1'b1;
    rid = arid;
    step();
    rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
    step();
  endtask

  initial begin
    step();
    check("rst_busy", busy, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    #2 rst = 1'b0;
    step();
    // single read from port 1, two wait cycles in R
    set_req(1, 1'b0, 32'h8000_0004, 3'd2, 32'h0, 4'h0);
    step();
    check("rd_arvalid", arvalid, 1);
    check("rd_araddr", araddr, 32'h8000_0004);
    check("rd_arid", arid, 1);
    check("rd_arsize", arsize, 2);
    check("rd_arlen", arlen, 0);
    check("rd_arburst", arburst, 1);
    serve_read(64'h1122_3344_5566_7788, 2'b00, 2, g);
    check("rd_resp_valid", resp_valid, 3'b010);
    check("rd_rdata", resp_rdata, 32'h1122_3344);
    check("rd_err", resp_err, 0);
    req_valid = '0;
    step();
    check("rd_once", resp_valid, 0);
    // contention: all three ports read continuously
    do_reset();
    for (int p = 0; p < NREQ; p++) set_req(p, 1'b0, 32'h8000_0000 + 32'(p * 16), 3'd2, 32'h0, 4'h0);
    for (int t = 0; t < 6; t++) begin
      serve_read(64'h0, 2'b00, 0, g);
      check("rr_order", 64'(g), 64'(t % 3));
      check("rr_resp", resp_valid, 64'(1 << (t % 3)));
    end
    req_valid = '0;
    step();
    // write with AW accepted three cycles before W
    awready = 1'b0;
    wready = 1'b0;
    set_req(0, 1'b1, 32'h8000_0006, 3'd1, 32'hAABB_CCDD, 4'h3);
    step();
    check("wa_awvalid", awvalid, 1);
    check("wa_wvalid", wvalid, 1);
    check("wa_wstrb", wstrb, 8'hC0);
    check("wa_wdata", wdata, 64'hCCDD_0000_CCDD_0000);
    check("wa_wlast", wlast, 1);
    check("wa_awaddr", awaddr, 32'h8000_0006);
    check("wa_awsize", awsize, 1);
    check("wa_awid", awid, 0);
    awready = 1'b1;
    step();
    awready = 1'b0;
    check("wa_aw_drop", awvalid, 0);
    check("wa_w_hold", wvalid, 1);
    step();
    step();
    check("wa_w_wait", wvalid, 1);
    wready = 1'b1;
    step();
    wready = 1'b0;
    check("wa_w_drop", wvalid, 0);
    check("wa_bready", bready, 1);
    check("wa_no_early_resp", resp_valid, 0);
    bvalid = 1'b1;
    bid = 4'd0;
    bresp = 2'b00;
    step();
    bvalid = 1'b0;
    check("wa_resp_valid", resp_valid, 3'b001);
    check("wa_err", resp_err, 0);
    req_valid = '0;
    // write with AW and W in the same cycle, slave reports SLVERR
    awready = 1'b1;
    wready = 1'b1;
    set_req(2, 1'b1, 32'h8000_0000, 3'd2, 32'h1234_5678, 4'hF);
    step();
    step();
    check("ws_awvalid", awvalid, 1);
    check("ws_wvalid", wvalid, 1);
    check("ws_wdata", wdata, 64'h1234_5678_1234_5678);
    check("ws_wstrb", wstrb, 8'h0F);
    step();
    check("ws_bready", bready, 1);
    check("ws_aw_once", awvalid, 0);
    check("ws_w_once", wvalid, 0);
    bvalid = 1'b1;
    bid = 4'd2;
    bresp = 2'b10;
    step();
    bvalid = 1'b0;
    bresp = 2'b00;
    check("ws_resp_valid", resp_valid, 3'b100);
    check("ws_err", resp_err, 1);
    req_valid = '0;
    // following read reports no error, low lane selected
    set_req(0, 1'b0, 32'h8000_0008, 3'd2, 32'h0, 4'h0);
    serve_read(64'hDEAD_BEEF_CAFE_F00D, 2'b00, 0, g);
    check("ok_grant", 64'(g), 0);
    check("ok_resp_valid", resp_valid, 3'b001);
    check("ok_err", resp_err, 0);
    check("ok_rdata", resp_rdata, 32'hCAFE_F00D);
    req_valid = '0;
    // asynchronous reset while in R
    set_req(1, 1'b0, 32'h8000_0004, 3'd2, 32'h0, 4'h0);
    for (int k = 0; k < 20 && !rready; k++) step();
    check("ar_r_reached", rready, 1);
    set_req(0, 1'b0, 32'h8000_0010, 3'd2, 32'h0, 4'h0);
    #3 rst = 1'b1;
    #1;
    check("ar_rready", rready, 0);
    check("ar_arvalid", arvalid, 0);
    check("ar_awvalid", awvalid, 0);
    check("ar_wvalid", wvalid, 0);
    check("ar_bready", bready, 0);
    check("ar_busy", busy, 0);
    check("ar_resp_valid", resp_valid, 0);
    step();
    #2 rst = 1'b0;
    serve_read(64'h0000_0000_0000_0042, 2'b00, 0, g);
    check("ar_first_grant", 64'(g), 0);
    check("ar_after_resp", resp_valid, 3'b001);
    req_valid = '0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
